// File: rtl/noc_spike_packetizer.sv
// noc_spike_packetizer
//   Network-clock stage behind the CPU-to-network async FIFO. Pops spike
//   descriptors from a first-word-fall-through FIFO and groups consecutive
//   words for the same destination router into one wormhole packet
//   (HEAD, BODY*, TAIL) on the router local input port.
//   A burst is closed by the length cap, a destination change or an idle
//   timeout on an empty FIFO.
//
// Ports:
//   clk           network clock
//   reset         synchronous, active-high reset
//   fifo_rd_en    pop strobe to the FIFO (combinational)
//   fifo_rd_data  FIFO head word, valid while fifo_empty=0
//   fifo_empty    FIFO empty flag
//   flit_out      {type[1:0], payload}, registered
//   flit_valid    flit_out valid, registered
//   flit_ready    router accepts the flit
//   busy          high whenever a packet is in progress (state != IDLE)
module noc_spike_packetizer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned TIMEOUT    = 8,
    parameter logic [3:0]  SRC_X      = 4'd0,
    parameter logic [3:0]  SRC_Y      = 4'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH+1:0] flit_out,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  busy
);

    localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_WAIT,
        S_TAIL
    } state_t;

    state_t                r_state, w_state_nx;
    logic [DATA_WIDTH-1:0] r_hold, w_hold_nx;
    logic [7:0]            r_cur_dest, w_cur_dest_nx;
    logic [BEAT_W-1:0]     r_beat_cnt, w_beat_nx;
    logic [WAIT_W-1:0]     r_wait_cnt, w_wait_nx;
    logic [DATA_WIDTH+1:0] r_flit, w_flit_nx;
    logic                  r_valid, w_valid_nx;

    logic [7:0]            w_dest;
    logic [DATA_WIDTH-1:0] w_head_payload;
    logic                  w_xfer;
    logic                  w_decide;
    logic                  w_more;
    logic                  w_close;
    logic                  w_pop;

    assign w_dest = fifo_rd_data[DATA_WIDTH-1 -: 8];
    assign w_xfer = r_valid & flit_ready;

    // HEAD is only built in IDLE, where cur_dest is being loaded from w_dest.
    always_comb begin
        w_head_payload = '0;
        w_head_payload[DATA_WIDTH-1 -: 16] = {w_dest, SRC_X, SRC_Y};
    end

    // Burst continuation / closing conditions, in priority order (more wins).
    assign w_more  = !fifo_empty && (w_dest == r_cur_dest) && (r_beat_cnt < BEAT_LAST);
    assign w_close = (r_beat_cnt == BEAT_LAST)
                   || (!fifo_empty && (w_dest != r_cur_dest))
                   || (r_wait_cnt >= WAIT_LIMIT);

    // WAIT has no flit pending, so it re-evaluates every cycle.
    assign w_decide = (((r_state == S_HEAD) || (r_state == S_BODY)) && w_xfer)
                    || (r_state == S_WAIT);

    always_comb begin
        w_state_nx    = r_state;
        w_hold_nx     = r_hold;
        w_cur_dest_nx = r_cur_dest;
        w_beat_nx     = r_beat_cnt;
        w_wait_nx     = r_wait_cnt;
        w_flit_nx     = r_flit;
        w_valid_nx    = r_valid;
        w_pop         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_pop         = 1'b1;
                    w_hold_nx     = fifo_rd_data;
                    w_cur_dest_nx = w_dest;
                    w_flit_nx     = {T_HEAD, w_head_payload};
                    w_valid_nx    = 1'b1;
                    w_state_nx    = S_HEAD;
                end
            end
            S_TAIL: begin
                if (w_xfer) begin
                    w_valid_nx = 1'b0;
                    w_beat_nx  = '0;
                    w_wait_nx  = '0;
                    w_state_nx = S_IDLE;
                end
            end
            default: ;
        endcase

        if (w_decide) begin
            if (w_more) begin
                w_flit_nx  = {T_BODY, r_hold};
                w_pop      = 1'b1;
                w_hold_nx  = fifo_rd_data;
                w_beat_nx  = r_beat_cnt + 1'b1;
                w_wait_nx  = '0;
                w_valid_nx = 1'b1;
                w_state_nx = S_BODY;
            end else if (w_close) begin
                w_flit_nx  = {T_TAIL, r_hold};
                w_valid_nx = 1'b1;
                w_state_nx = S_TAIL;
            end else begin
                w_valid_nx = 1'b0;
                if (r_wait_cnt != WAIT_LIMIT) begin
                    w_wait_nx = r_wait_cnt + 1'b1;
                end
                w_state_nx = S_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_cur_dest <= '0;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
            r_flit     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_hold     <= w_hold_nx;
            r_cur_dest <= w_cur_dest_nx;
            r_beat_cnt <= w_beat_nx;
            r_wait_cnt <= w_wait_nx;
            r_flit     <= w_flit_nx;
            r_valid    <= w_valid_nx;
        end
    end

    // A pop must never happen while reset discards the captured word.
    assign fifo_rd_en = w_pop & ~reset;
    assign flit_out   = r_flit;
    assign flit_valid = r_valid;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_noc_spike_packetizer.sv
// tb_noc_spike_packetizer
//   Scoreboard bench for noc_spike_packetizer (DATA_WIDTH=32, MAX_BURST=4,
//   TIMEOUT=8, SRC_X=1, SRC_Y=2). A queue models the FWFT FIFO; expected
//   flits are queued per scenario and matched on every accepted flit.
module tb_noc_spike_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        fifo_empty;
    logic [33:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic        busy;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          pops        = 0;

    logic [31:0] fq[$];
    logic [33:0] exp_q[$];
    int          xfer_cyc[$];

    localparam logic [33:0] HEAD34 = {2'b01, 32'h34120000};
    localparam logic [33:0] HEAD56 = {2'b01, 32'h56120000};

    noc_spike_packetizer #(
        .DATA_WIDTH(32),
        .MAX_BURST (4),
        .TIMEOUT   (8),
        .SRC_X     (4'd1),
        .SRC_Y     (4'd2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .flit_out    (flit_out),
        .flit_valid  (flit_valid),
        .flit_ready  (flit_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic refresh();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : 32'h0;
    endtask

    task automatic fifo_push(input logic [31:0] w);
        fq.push_back(w);
        refresh();
    endtask

    // One clock: scoreboard/pop sampling at negedge, FIFO update after posedge.
    task automatic step();
        logic        p;
        logic [33:0] e;
        @(negedge clk);
        p = fifo_rd_en;
        if (p) begin
            pops++;
            vectors++;
            if (fifo_empty !== 1'b0) begin
                miscompares++;
                $display("FAIL pop_when_empty fifo_empty=%b want 0", fifo_empty);
            end
        end
        if (!reset && flit_valid === 1'b1 && flit_ready === 1'b1) begin
            vectors++;
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_flit got %h want none", flit_out);
            end else begin
                e = exp_q.pop_front();
                if (flit_out !== e) begin
                    miscompares++;
                    $display("FAIL flit got %h want %h (cycle %0d)", flit_out, e, cyc);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (p && fq.size() != 0) void'(fq.pop_front());
        refresh();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && !(exp_q.size() == 0 && busy === 1'b0 &&
                               flit_valid === 1'b0 && fq.size() == 0)) begin
            step();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_idle_timeout got %0d pending flits want 0", name, exp_q.size());
        end
    endtask

    task automatic check_gap(input string name, input int idx, input int want);
        vectors++;
        if (idx >= xfer_cyc.size()) begin
            miscompares++;
            $display("FAIL %s_gap%0d got missing flit want gap %0d", name, idx, want);
        end else if (xfer_cyc[idx] - xfer_cyc[idx-1] != want) begin
            miscompares++;
            $display("FAIL %s_gap%0d got %0d want %0d", name, idx,
                     xfer_cyc[idx] - xfer_cyc[idx-1], want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        vectors++;
        if (flit_valid !== 1'b0 || flit_out !== 34'h0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got v=%b out=%h busy=%b rd=%b want 0 0 0 0",
                     flit_valid, flit_out, busy, fifo_rd_en);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (flit_valid !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got v=%b busy=%b rd=%b want 0 0 0",
                     flit_valid, busy, fifo_rd_en);
        end
    endtask

    task automatic test_single();
        int c0, p0;
        xfer_cyc.delete();
        p0 = pops;
        c0 = cyc;
        exp_q.push_back(HEAD34);
        exp_q.push_back({2'b10, 32'h340000AA});
        fifo_push(32'h340000AA);
        wait_idle(40, "single");
        vectors++;
        if (xfer_cyc.size() < 1 || xfer_cyc[0] != c0 + 1) begin
            miscompares++;
            $display("FAIL single_head_latency got %0d want %0d",
                     (xfer_cyc.size() > 0) ? xfer_cyc[0] - c0 : -1, 1);
        end
        check_gap("single", 1, 9);
        vectors++;
        if (pops - p0 != 1) begin
            miscompares++;
            $display("FAIL single_pops got %0d want 1", pops - p0);
        end
    endtask

    task automatic test_burst();
        int p0;
        logic [31:0] w;
        xfer_cyc.delete();
        p0 = pops;
        exp_q.push_back(HEAD34);
        for (int i = 1; i <= 3; i++) begin
            w = 32'h34000010 + 32'(i);
            exp_q.push_back({2'b00, w});
        end
        exp_q.push_back({2'b10, 32'h34000014});
        exp_q.push_back(HEAD34);
        exp_q.push_back({2'b00, 32'h34000015});
        exp_q.push_back({2'b10, 32'h34000016});
        for (int i = 1; i <= 6; i++) begin
            w = 32'h34000010 + 32'(i);
            fifo_push(w);
        end
        wait_idle(60, "burst");
        for (int i = 1; i <= 4; i++) check_gap("burst", i, 1);
        check_gap("burst", 5, 2);
        check_gap("burst", 6, 1);
        check_gap("burst", 7, 9);
        vectors++;
        if (pops - p0 != 6) begin
            miscompares++;
            $display("FAIL burst_pops got %0d want 6", pops - p0);
        end
    endtask

    task automatic test_dest_change();
        int p0;
        xfer_cyc.delete();
        p0 = pops;
        exp_q.push_back(HEAD34);
        exp_q.push_back({2'b10, 32'h34000001});
        exp_q.push_back(HEAD56);
        exp_q.push_back({2'b10, 32'h56000002});
        fifo_push(32'h34000001);
        fifo_push(32'h56000002);
        wait_idle(50, "dest");
        check_gap("dest", 1, 1);
        check_gap("dest", 2, 2);
        check_gap("dest", 3, 9);
        vectors++;
        if (pops - p0 != 2) begin
            miscompares++;
            $display("FAIL dest_pops got %0d want 2", pops - p0);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        p0 = pops;
        flit_ready = 1'b0;
        exp_q.push_back(HEAD34);
        exp_q.push_back({2'b00, 32'h34000071});
        exp_q.push_back({2'b10, 32'h34000072});
        fifo_push(32'h34000071);
        fifo_push(32'h34000072);
        step();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (flit_valid !== 1'b1 || flit_out !== HEAD34 || fifo_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL stall%0d got v=%b out=%h rd=%b want 1 %h 0",
                         i, flit_valid, flit_out, fifo_rd_en, HEAD34);
            end
            step();
        end
        flit_ready = 1'b1;
        wait_idle(50, "stall");
        vectors++;
        if (pops - p0 != 2) begin
            miscompares++;
            $display("FAIL stall_pops got %0d want 2", pops - p0);
        end
    endtask

    task automatic test_late_word();
        int c0;
        xfer_cyc.delete();
        c0 = cyc;
        exp_q.push_back(HEAD34);
        exp_q.push_back({2'b00, 32'h340000A1});
        exp_q.push_back({2'b10, 32'h340000A2});
        fifo_push(32'h340000A1);
        repeat (6) step();
        fifo_push(32'h340000A2);
        wait_idle(40, "late");
        vectors++;
        if (xfer_cyc.size() < 2 || xfer_cyc[1] != c0 + 7) begin
            miscompares++;
            $display("FAIL late_body_cycle got %0d want %0d",
                     (xfer_cyc.size() > 1) ? xfer_cyc[1] - c0 : -1, 7);
        end
        check_gap("late", 2, 9);
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = pops;
        exp_q.push_back(HEAD34);
        exp_q.push_back(HEAD34);
        exp_q.push_back({2'b10, 32'h340000C3});
        fifo_push(32'h340000C1);
        fifo_push(32'h340000C2);
        fifo_push(32'h340000C3);
        step();
        step();
        flit_ready = 1'b0;
        reset      = 1'b1;
        #1;
        vectors++;
        if (flit_valid !== 1'b1 || flit_out !== {2'b00, 32'h340000C1} || fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pending got v=%b out=%h rd=%b want 1 %h 0",
                     flit_valid, flit_out, fifo_rd_en, {2'b00, 32'h340000C1});
        end
        step();
        vectors++;
        if (flit_valid !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid got v=%b busy=%b rd=%b want 0 0 0",
                     flit_valid, busy, fifo_rd_en);
        end
        reset      = 1'b0;
        flit_ready = 1'b1;
        wait_idle(40, "rstmid");
        vectors++;
        if (pops - p0 != 3) begin
            miscompares++;
            $display("FAIL rstmid_pops got %0d want 3", pops - p0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        flit_ready = 1'b1;
        refresh();
        test_reset();
        test_single();
        test_burst();
        test_dest_change();
        test_backpressure();
        test_late_word();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
